etc_raster_buf: RTL

- Reorders decoded ETC2 pixels from 4x4-block order into raster order for the TFT pixel stage.
- Sits between the ETC2 decoder pixel output and the TFT pixel generator.
- Holds one 4-row strip while the next strip is written into a second bank (double-buffered).
- Emits a valid/ready raster stream with start-of-frame and end-of-line markers.

---
 rtl/etc_raster_buf.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/etc_raster_buf.sv
// etc_raster_buf: reorders ETC2 4x4-block pixels into raster order.
// Two RAM banks each hold one 4-row strip; the writer fills one bank while
// the reader streams the other out through a 2-entry skid buffer.
module etc_raster_buf #(
    parameter int IMG_W = 480,
    parameter int IMG_H = 272,
    parameter int PIX_W = 16
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_sof,
    output logic             out_eol,
    output logic             frame_done
);
    localparam int BLK_N  = IMG_W / 4;
    localparam int STRIPS = IMG_H / 4;
    localparam int DEPTH  = 8 * IMG_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int BXW    = (BLK_N > 1) ? $clog2(BLK_N) : 1;
    localparam int CW     = $clog2(IMG_W);
    localparam int SYW    = (STRIPS > 1) ? $clog2(STRIPS) : 1;

    localparam logic [BXW-1:0] BX_LAST    = BXW'(BLK_N - 1);
    localparam logic [CW-1:0]  C_LAST     = CW'(IMG_W - 1);
    localparam logic [SYW-1:0] SY_LAST    = SYW'(STRIPS - 1);
    localparam logic [AW-1:0]  ROW_WORDS  = AW'(IMG_W);
    localparam logic [AW-1:0]  BANK_WORDS = AW'(4 * IMG_W);

    // Raster markers travel alongside each pixel from read issue to output.
    typedef struct packed {
        logic sof;
        logic eol;
        logic last;
    } tag_t;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        tag_t             tag;
    } skid_t;

    // Writer state: target bank, pixel-in-block and block-in-strip counters.
    logic           wb_q, wb_d;
    logic [3:0]     k_q, k_d;
    logic [BXW-1:0] bx_q, bx_d;
    // Bank occupancy flags shared by writer and reader.
    logic [1:0]     full_q, full_d;
    // Reader state: source bank, row, column and strip counters.
    logic           rb_q, rb_d;
    logic [1:0]     r_q, r_d;
    logic [CW-1:0]  c_q, c_d;
    logic [SYW-1:0] sy_q, sy_d;
    // RAM read in flight and its markers.
    logic           rd_vld_q, rd_vld_d;
    tag_t           rd_tag_q, rd_tag_d;
    logic [PIX_W-1:0] rdata_q;
    // Skid buffer: two entries with separate write/read pointers.
    skid_t          skid_q [2];
    skid_t          skid_d [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     occ_q, occ_d;

    logic [PIX_W-1:0] ram [DEPTH];

    logic          wr_fire, wr_last, rd_fire, rd_last, pop;
    logic [AW-1:0] waddr, raddr;
    skid_t         head;

    assign in_ready  = ~full_q[wb_q];
    assign wr_fire   = in_valid & in_ready & ~flush;
    assign wr_last   = (k_q == 4'hF) && (bx_q == BX_LAST);

    assign head      = skid_q[rd_ptr_q];
    assign out_valid = (occ_q != 2'd0);
    assign out_pix   = head.pix;
    assign out_sof   = out_valid & head.tag.sof;
    assign out_eol   = out_valid & head.tag.eol;
    assign pop       = out_valid & out_ready;
    assign frame_done = pop & head.tag.last & ~flush;

    // A read may issue when the strip is complete and the skid buffer, counting
    // the read in flight and any pop this cycle, still has a free slot.
    assign rd_fire = full_q[rb_q] & ~flush &
                     (({1'b0, occ_q} + {2'b0, rd_vld_q}) < (3'd2 + {2'b0, pop}));
    assign rd_last = (r_q == 2'd3) && (c_q == C_LAST);

    // Block order, column-major within a block: x = bx*4 + k[3:2], y = k[1:0].
    assign waddr = (wb_q ? BANK_WORDS : '0) + AW'(k_q[1:0]) * ROW_WORDS
                 + AW'({bx_q, k_q[3:2]});
    assign raddr = (rb_q ? BANK_WORDS : '0) + AW'(r_q) * ROW_WORDS + AW'(c_q);

    // Strip RAM: one write port from the decoder, one registered read port.
    // NOTE: the RAM has no reset so it maps onto block RAM; valid flags, not
    // contents, decide what is ever presented downstream.
    always_ff @(posedge sclk) begin
        if (wr_fire) begin
            ram[waddr] <= in_pix;
        end
        if (rd_fire) begin
            rdata_q <= ram[raddr];
        end
    end

    // Next-state logic for counters, bank flags and the skid buffer.
    always_comb begin
        // NOTE: every _d starts from its _q value so no path leaves it
        // unassigned and no latch is inferred.
        wb_d     = wb_q;
        k_d      = k_q;
        bx_d     = bx_q;
        full_d   = full_q;
        rb_d     = rb_q;
        r_d      = r_q;
        c_d      = c_q;
        sy_d     = sy_q;
        rd_vld_d = rd_fire;
        rd_tag_d = rd_tag_q;
        skid_d   = skid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q + {1'b0, rd_vld_q} - {1'b0, pop};

        if (wr_fire) begin
            k_d = k_q + 4'd1;
            if (k_q == 4'hF) begin
                bx_d = wr_last ? '0 : bx_q + BXW'(1);
            end
            if (wr_last) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end

        if (rd_fire) begin
            rd_tag_d.sof  = (sy_q == '0) && (r_q == 2'd0) && (c_q == '0);
            rd_tag_d.eol  = (c_q == C_LAST);
            rd_tag_d.last = (sy_q == SY_LAST) && rd_last;
            c_d = (c_q == C_LAST) ? '0 : c_q + CW'(1);
            if (c_q == C_LAST) begin
                r_d = r_q + 2'd1;
            end
            // The writer only sets a bank that is empty and the reader only
            // clears one that is full, so both updates can land together.
            if (rd_last) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                sy_d         = (sy_q == SY_LAST) ? '0 : sy_q + SYW'(1);
            end
        end

        if (rd_vld_q) begin
            skid_d[wr_ptr_q] = '{pix: rdata_q, tag: rd_tag_q};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (flush) begin
            wb_d     = 1'b0;
            k_d      = '0;
            bx_d     = '0;
            full_d   = '0;
            rb_d     = 1'b0;
            r_d      = '0;
            c_d      = '0;
            sy_d     = '0;
            rd_vld_d = 1'b0;
            rd_tag_d = '0;
            skid_d   = '{default: '0};
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            wb_q     <= 1'b0;
            k_q      <= '0;
            bx_q     <= '0;
            full_q   <= '0;
            rb_q     <= 1'b0;
            r_q      <= '0;
            c_q      <= '0;
            sy_q     <= '0;
            rd_vld_q <= 1'b0;
            rd_tag_q <= '0;
            skid_q   <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            wb_q     <= wb_d;
            k_q      <= k_d;
            bx_q     <= bx_d;
            full_q   <= full_d;
            rb_q     <= rb_d;
            r_q      <= r_d;
            c_q      <= c_d;
            sy_q     <= sy_d;
            rd_vld_q <= rd_vld_d;
            rd_tag_q <= rd_tag_d;
            skid_q   <= skid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule
